// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer and the single-bit shift unit it drives.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_A_RIGHT = 2'b00;
    localparam logic [1:0] OP_A_LEFT  = 2'b01;

endpackage

// File: rtl/shift_sequencer.sv
// Turns "shift by N" into N single-bit shift-unit transactions, feeding each result back.
// Optional SHIFT_SEQ_ERR_EN: missing sh_flag in WAIT aborts with err=1 and the partial result.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] sh_A,
    output logic [WIDTH-1:0] sh_B,
    output logic [1:0]       sh_OP,
    output logic             sh_enable,
    input  logic [WIDTH-1:0] sh_out,
    input  logic             sh_flag
`ifdef SHIFT_SEQ_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_count;
    logic             r_dir;
    logic [WIDTH-1:0] r_dout;
    logic [AMT_W-1:0] w_amt;
    logic             w_accept;
    logic             w_last;

    // Amounts beyond WIDTH shift everything out, so WIDTH steps give the same result.
    assign w_amt    = (amount > AMT_MAX) ? AMT_MAX : amount;
    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_count == AMT_ONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (w_amt == '0) ? DONE : ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (sh_flag) w_next = w_last ? DONE : ISSUE;
`ifdef SHIFT_SEQ_ERR_EN
                else         w_next = DONE;
`endif
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // dout is loaded on the edge entering DONE so it is valid alongside the done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_work  <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_dout  <= '0;
`ifdef SHIFT_SEQ_ERR_EN
            err     <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_work  <= din;
                r_dir   <= dir;
                r_count <= w_amt;
`ifdef SHIFT_SEQ_ERR_EN
                err     <= 1'b0;
`endif
                if (w_amt == '0) r_dout <= din;
            end
            if (r_state == WAIT) begin
                if (sh_flag) begin
                    r_work  <= sh_out;
                    r_count <= r_count - AMT_ONE;
                    if (w_last) r_dout <= sh_out;
                end
`ifdef SHIFT_SEQ_ERR_EN
                else begin
                    err    <= 1'b1;
                    r_dout <= r_work;
                end
`endif
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign sh_enable = (r_state == ISSUE);
    assign sh_A      = r_work;
    assign sh_B      = '0;
    assign sh_OP     = r_dir ? OP_A_LEFT : OP_A_RIGHT;
    assign dout      = r_dout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a behavioural single-bit shift unit as responder.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int W = 16;
    localparam int A = 5;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic [A-1:0] amount = '0;
    logic         dir = 1'b0;
    logic         busy, done, sh_enable, sh_flag;
    logic [W-1:0] dout, sh_A, sh_B, sh_out;
    logic [1:0]   sh_OP;
`ifdef SHIFT_SEQ_ERR_EN
    logic         err;
`endif

    int vectors = 0;
    int miscompares = 0;
    int drop_step = 0;
    int en_cnt;
    logic rst_n;

    shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
        .CLK(CLK), .RST(RST), .start(start), .din(din), .amount(amount), .dir(dir),
        .busy(busy), .done(done), .dout(dout), .sh_A(sh_A), .sh_B(sh_B), .sh_OP(sh_OP),
        .sh_enable(sh_enable), .sh_out(sh_out), .sh_flag(sh_flag)
`ifdef SHIFT_SEQ_ERR_EN
        , .err(err)
`endif
    );

    always #5 CLK = ~CLK;

    // Shift unit: active-low reset, one-cycle registered result and flag.
    assign rst_n = ~RST;
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sh_out  <= '0;
            sh_flag <= 1'b0;
            en_cnt  <= 0;
        end else begin
            sh_flag <= sh_enable && !(drop_step != 0 && en_cnt + 1 == drop_step);
            if (sh_enable) sh_out <= (sh_OP == OP_A_LEFT) ? (sh_A << 1) : (sh_A >> 1);
            if (start && !busy) en_cnt <= 0;
            else if (sh_enable) en_cnt <= en_cnt + 1;
        end
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic d, input int n);
        int k;
        logic [W-1:0] r;
        k = (n > W) ? W : n;
        r = a;
        for (int i = 0; i < k; i++) r = d ? (r << 1) : (r >> 1);
        return r;
    endfunction

    function automatic int steps(input int n);
        return (n > W) ? W : n;
    endfunction

    // Drives one operation and measures it; poke>0 injects a junk start at that cycle.
    task automatic run_op(input logic [W-1:0] a, input logic d, input int amt, input int poke,
                          output logic [W-1:0] res, output int cyc, output int pulses,
                          output int bad);
        @(negedge CLK);
        din = a; dir = d; amount = A'(amt); start = 1'b1;
        cyc = 0; pulses = 0; bad = 0; res = 'x;
        forever begin
            @(negedge CLK);
            cyc++;
            if (poke > 0 && cyc == poke) begin
                start = 1'b1; din = ~a; dir = ~d; amount = 5'd1;
            end else start = 1'b0;
            if (sh_enable) begin
                if (sh_A !== model(a, d, pulses) || sh_OP !== {1'b0, d} || sh_B !== '0) bad++;
                pulses++;
            end
            if (done) begin
                res = dout;
                break;
            end
            if (cyc >= 120) begin
                vectors++; miscompares++;
                $display("FAIL run_op timeout: no done after %0d cycles", cyc);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        vectors += 7;
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)      begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        if (sh_enable !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b want 0", sh_enable); end
        if (sh_OP !== 2'b00)    begin miscompares++; $display("FAIL reset_op got %b want 00", sh_OP); end
        if (sh_A !== '0)        begin miscompares++; $display("FAIL reset_shA got %h want 0", sh_A); end
        if (sh_B !== '0)        begin miscompares++; $display("FAIL reset_shB got %h want 0", sh_B); end
        if (dout !== '0)        begin miscompares++; $display("FAIL reset_dout got %h want 0", dout); end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_left_basic();
        logic [W-1:0] r; int c, p, b;
        run_op(16'h00F0, 1'b1, 4, 0, r, c, p, b);
        vectors += 4;
        if (r !== 16'h0F00) begin miscompares++; $display("FAIL left_dout got %h want 0f00", r); end
        if (c !== 9)        begin miscompares++; $display("FAIL left_latency got %0d want 9", c); end
        if (p !== 4)        begin miscompares++; $display("FAIL left_pulses got %0d want 4", p); end
        if (b !== 0)        begin miscompares++; $display("FAIL left_issue got %0d bad want 0", b); end
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL left_idle busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_right_basic();
        logic [W-1:0] r; int c, p, b;
        run_op(16'h8001, 1'b0, 3, 0, r, c, p, b);
        vectors += 3;
        if (r !== 16'h1000) begin miscompares++; $display("FAIL right_dout got %h want 1000", r); end
        if (c !== 7)        begin miscompares++; $display("FAIL right_latency got %0d want 7", c); end
        if (b !== 0)        begin miscompares++; $display("FAIL right_op got %0d bad issues want 0", b); end
    endtask

    task automatic test_zero_amount();
        logic [W-1:0] r; int c, p, b;
        run_op(16'hBEEF, 1'b1, 0, 0, r, c, p, b);
        vectors += 3;
        if (r !== 16'hBEEF) begin miscompares++; $display("FAIL zero_dout got %h want beef", r); end
        if (c !== 1)        begin miscompares++; $display("FAIL zero_latency got %0d want 1", c); end
        if (p !== 0)        begin miscompares++; $display("FAIL zero_pulses got %0d want 0", p); end
    endtask

    task automatic test_clamp();
        logic [W-1:0] r; int c, p, b;
        run_op(16'hFFFF, 1'b1, 20, 0, r, c, p, b);
        vectors += 3;
        if (r !== 16'h0000) begin miscompares++; $display("FAIL clamp_dout got %h want 0000", r); end
        if (c !== 33)       begin miscompares++; $display("FAIL clamp_latency got %0d want 33", c); end
        if (p !== 16)       begin miscompares++; $display("FAIL clamp_pulses got %0d want 16", p); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r; int c, p, b, en, n; bit seen;
        run_op(16'hBEEF, 1'b0, 0, 0, r, c, p, b);
        @(negedge CLK);
        din = 16'h1234; dir = 1'b1; amount = 5'd8; start = 1'b1;
        en = 0; n = 0;
        forever begin
            @(negedge CLK);
            start = 1'b0; n++;
            if (sh_enable) en++;
            else if (en == 3) break;
            if (n > 50) begin
                vectors++; miscompares++;
                $display("FAIL rstmid_wait timeout after %0d cycles", n);
                break;
            end
        end
        #2 RST = 1'b1;
        #1;
        vectors += 4;
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (sh_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_en got %b want 0", sh_enable); end
        if (dout !== '0)        begin miscompares++; $display("FAIL rstmid_dout got %h want 0", dout); end
        if (done !== 1'b0)      begin miscompares++; $display("FAIL rstmid_done got %b want 0", done); end
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge CLK);
            if (done || busy) seen = 1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL rstmid_quiet got activity want none"); end
        run_op(16'h0002, 1'b0, 1, 0, r, c, p, b);
        vectors += 2;
        if (r !== 16'h0001) begin miscompares++; $display("FAIL rstmid_next got %h want 0001", r); end
        if (c !== 3)        begin miscompares++; $display("FAIL rstmid_lat got %0d want 3", c); end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] r; int c, p, b;
        run_op(16'h0003, 1'b1, 5, 4, r, c, p, b);
        vectors += 3;
        if (r !== 16'h0060) begin miscompares++; $display("FAIL ignore_dout got %h want 0060", r); end
        if (c !== 11)       begin miscompares++; $display("FAIL ignore_latency got %0d want 11", c); end
        if (b !== 0)        begin miscompares++; $display("FAIL ignore_issue got %0d bad want 0", b); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r; int c, p, b;
        run_op(16'hA5A5, 1'b0, 2, 0, r, c, p, b);
        run_op(16'h0F0F, 1'b1, 3, 0, r, c, p, b);
        vectors += 2;
        if (r !== 16'h7878) begin miscompares++; $display("FAIL b2b_dout got %h want 7878", r); end
        if (c !== 7)        begin miscompares++; $display("FAIL b2b_latency got %0d want 7", c); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, r; logic d; int amt, c, p, b;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            d = 1'($urandom_range(0, 1));
            amt = $urandom_range(0, 20);
            run_op(a, d, amt, 0, r, c, p, b);
            vectors += 4;
            if (r !== model(a, d, amt)) begin
                miscompares++;
                $display("FAIL rand_dout a=%h d=%b n=%0d got %h want %h", a, d, amt, r, model(a, d, amt));
            end
            if (c !== 2 * steps(amt) + 1) begin
                miscompares++; $display("FAIL rand_latency n=%0d got %0d want %0d", amt, c, 2 * steps(amt) + 1);
            end
            if (p !== steps(amt)) begin
                miscompares++; $display("FAIL rand_pulses n=%0d got %0d want %0d", amt, p, steps(amt));
            end
            if (b !== 0) begin miscompares++; $display("FAIL rand_issue got %0d bad want 0", b); end
        end
    endtask

`ifdef SHIFT_SEQ_ERR_EN
    task automatic test_err();
        logic [W-1:0] r; int c, p, b;
        drop_step = 2;
        run_op(16'h0001, 1'b1, 4, 0, r, c, p, b);
        vectors += 3;
        if (err !== 1'b1)   begin miscompares++; $display("FAIL err_flag got %b want 1", err); end
        if (r !== 16'h0002) begin miscompares++; $display("FAIL err_dout got %h want 0002", r); end
        if (p !== 2)        begin miscompares++; $display("FAIL err_pulses got %0d want 2", p); end
        drop_step = 0;
        run_op(16'h0001, 1'b1, 2, 0, r, c, p, b);
        vectors += 2;
        if (err !== 1'b0)   begin miscompares++; $display("FAIL err_clear got %b want 0", err); end
        if (r !== 16'h0004) begin miscompares++; $display("FAIL err_next got %h want 0004", r); end
    endtask
`endif

    initial begin
        test_reset();
        test_left_basic();
        test_right_basic();
        test_zero_amount();
        test_clamp();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        test_random();
`ifdef SHIFT_SEQ_ERR_EN
        test_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
